// File: rtl/dma_pkg.sv
// Shared types for the MM2S stream sink: FSM states and the FIFO entry tag.
// A FIFO entry is {sink_tag_t, data}; err is the MSB of the entry.
package dma_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StDrop
   } sink_state_e;

   typedef struct packed {
      logic err;
      logic last;
   } sink_tag_t;

   localparam int unsigned TagWidth  = 2;
   localparam sink_tag_t   DataTag   = '{err: 1'b0, last: 1'b0};
   localparam sink_tag_t   MarkerTag = '{err: 1'b1, last: 1'b1};

endpackage

// File: rtl/dma_mm2s_stream_sink_if.sv
// AXI-Stream beat bundle between the MM2S read path and the stream sink.
interface dma_mm2s_stream_sink_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic                    tvalid;
   logic                    tready;

   modport master (
      output tdata, tkeep, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tlast, tvalid,
      output tready
   );

endinterface

// File: rtl/dma_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes when full and pops when empty are ignored.
module dma_sync_fifo #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == (PtrW + 1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) level_d = level_q + 1'b1;
      if (pop_ok && !push_ok) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/dma_mm2s_stream_sink.sv
// MM2S stream sink: masks bytes by TKEEP, enforces the PMP verdict per packet and buffers
// beats in a FWFT FIFO, with saturating packet/drop counters and a sticky violation flag.
module dma_mm2s_stream_sink
   import dma_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   dma_mm2s_stream_sink_if.slave     s_axis,
   input  logic                      pmp_allow_i,
   input  logic                      pop_i,
   output logic                      pop_valid_o,
   output logic [DATA_WIDTH-1:0]     pop_data_o,
   output logic                      pop_last_o,
   output logic                      pop_err_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic [CNT_WIDTH-1:0]      pkt_cnt_o,
   output logic [CNT_WIDTH-1:0]      drop_cnt_o,
   output logic                      pmp_err_o,
   input  logic                      clr_i
);

   localparam int unsigned EntryW = TagWidth + DATA_WIDTH;
   localparam int unsigned KeepW  = DATA_WIDTH / 8;

   sink_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
   logic                  pmp_err_q, pmp_err_d;

   logic                  tready, accept, full, empty;
   logic                  push, pkt_inc, drop_inc, err_set;
   sink_tag_t             push_tag, head_tag;
   logic [DATA_WIDTH-1:0] push_data, masked_data;
   logic [EntryW-1:0]     fifo_rdata;

   // While dropping, beats are swallowed regardless of FIFO occupancy.
   assign tready        = (state_q == StDrop) | ~full;
   assign s_axis.tready = tready;
   assign accept        = s_axis.tvalid & tready;

   always_comb begin
      masked_data = '0;
      for (int unsigned i = 0; i < KeepW; i++) begin
         masked_data[8*i +: 8] = s_axis.tkeep[i] ? s_axis.tdata[8*i +: 8] : 8'h00;
      end
   end

   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      push_tag  = DataTag;
      push_data = masked_data;
      pkt_inc   = 1'b0;
      drop_inc  = 1'b0;
      err_set   = 1'b0;
      unique case (state_q)
         StIdle, StRecv: begin
            if (accept) begin
               if (pmp_allow_i) begin
                  push          = 1'b1;
                  push_tag.last = s_axis.tlast;
                  pkt_inc       = s_axis.tlast;
                  state_d       = s_axis.tlast ? StIdle : StRecv;
               end else begin
                  // A packet already partly stored is closed with an error marker.
                  push      = (state_q == StRecv);
                  push_tag  = MarkerTag;
                  push_data = '0;
                  drop_inc  = 1'b1;
                  err_set   = 1'b1;
                  state_d   = s_axis.tlast ? StIdle : StDrop;
               end
            end
         end
         StDrop: begin
            if (accept && s_axis.tlast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      pmp_err_d  = pmp_err_q | err_set;
      if (pkt_inc && pkt_cnt_q != '1)   pkt_cnt_d  = pkt_cnt_q + 1'b1;
      if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      if (clr_i) begin
         pkt_cnt_d  = '0;
         drop_cnt_d = '0;
         pmp_err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         pmp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         pmp_err_q  <= pmp_err_d;
      end
   end

   dma_sync_fifo #(
      .WIDTH (EntryW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  ({push_tag, push_data}),
      .pop_i   (pop_i),
      .data_o  (fifo_rdata),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level_o)
   );

   assign head_tag    = fifo_rdata[EntryW-1 -: TagWidth];
   assign pop_valid_o = ~empty;
   assign pop_data_o  = fifo_rdata[DATA_WIDTH-1:0];
   assign pop_last_o  = head_tag.last;
   assign pop_err_o   = head_tag.err;
   assign pkt_cnt_o   = pkt_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;
   assign pmp_err_o   = pmp_err_q;

endmodule

// File: doc/dma_mm2s_stream_sink.md
Name: dma_mm2s_stream_sink

Overview:
- Downstream consumer of the DMA MM2S AXI-Stream output (read-channel data after the PMP check).
- Buffers stream beats in a FIFO and masks invalid bytes using TKEEP.
- Enforces the registered PMP allow flag per packet: violating data is never stored, and partial packets are closed with an error marker.
- Exposes a first-word-fall-through pop port plus status counters for the DMA register map.

Parameters:
- DATA_WIDTH, 32, stream data width in bits (multiple of 8).
- DEPTH, 16, FIFO entries (power of 2, ≥2).
- CNT_WIDTH, 8, width of the packet and drop counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- s_axis_tdata_i  in  DATA_WIDTH  stream data
- s_axis_tkeep_i  in  DATA_WIDTH/8  byte valid
- s_axis_tlast_i  in  1  last beat of packet
- s_axis_tvalid_i  in  1  beat valid
- s_axis_tready_o  out  1  beat accepted when tvalid&tready
- pmp_allow_i  in  1  PMP verdict for the current source address (1 = allowed)
- pop_i  in  1  consume head entry
- pop_valid_o  out  1  FIFO not empty
- pop_data_o  out  DATA_WIDTH  head entry data
- pop_last_o  out  1  head entry closes a packet
- pop_err_o  out  1  head entry is a PMP-truncation marker
- level_o  out  $clog2(DEPTH)+1  current occupancy
- pkt_cnt_o  out  CNT_WIDTH  good packets completed (saturating)
- drop_cnt_o  out  CNT_WIDTH  packets dropped/truncated (saturating)
- pmp_err_o  out  1  sticky PMP-violation flag
- clr_i  in  1  clears pmp_err_o, pkt_cnt_o and drop_cnt_o

Behaviour:
- Reset values: all outputs 0 except s_axis_tready_o = 1. FIFO is empty and the FSM is in IDLE.
- Reset mid-packet flushes the FIFO. The next beat is treated as the first beat of a new packet.
- Entry format: {err, last, data}.
  - data bytes with tkeep=0 are stored as 0x00.
  - err entries store data = 0.
- FIFO:
  - First-word-fall-through. A beat accepted in cycle N gives pop_valid_o=1 in cycle N+1.
  - pop_i with pop_valid_o=0 is ignored.
  - Push and pop in the same cycle leave level_o unchanged.
  - No bypass: when full, s_axis_tready_o=0 even if pop_i=1.
- s_axis_tready_o:
  - In IDLE/RECV: equals !full.
  - In DROP: 1 (beats are discarded).
- FSM states:
  - IDLE (awaiting first beat)
  - RECV (inside a good packet)
  - DROP (discarding the remainder of a packet)
- IDLE, accepted beat:
  - pmp_allow_i=1: push the beat. If tlast, pkt_cnt++ and stay in IDLE; otherwise go to RECV.
  - pmp_allow_i=0: push nothing, set pmp_err, drop_cnt++. If tlast, stay in IDLE; otherwise go to DROP.
- RECV, accepted beat:
  - pmp_allow_i=1: push the beat. If tlast, pkt_cnt++ and go to IDLE.
  - pmp_allow_i=0: push the marker {err=1, last=1, data=0}, set pmp_err, drop_cnt++. If tlast, go to IDLE; otherwise go to DROP.
- DROP: discard every beat. On an accepted tlast, go to IDLE. Counters and flags are unchanged.
- Counters saturate at 2^CNT_WIDTH-1.
- clr_i has priority over a same-cycle increment or set: the result is 0.
- pmp_allow_i is sampled only on accepted beats.

Decomposition:
- dma_pkg:
  - sink_state_e enum {IDLE, RECV, DROP}
  - sink_entry_t struct {err, last, data}
  - localparams for the marker encoding
- Sub-module dma_sync_fifo:
  - parameterised width/depth, FWFT
  - outputs full, empty and level
  - synchronous active-high reset
- The top level holds the FSM, byte masking and counters.

Test Plan:
- Good packet: 3 beats 0x11223344/0x55667788/0xAABBCCDD, last on beat 3, pmp=1 → 3 pops with matching data, pop_last only on the 3rd, pkt_cnt_o=1, level_o returns to 0.
- TKEEP masking: beat 0xDEADBEEF, tkeep=4'b0101, tlast=1 → pop_data_o=0x00AD00EF.
- First-beat violation: 4-beat packet with pmp=0 → nothing pushed, tready=1 for all 4 beats, drop_cnt_o=1, pmp_err_o=1; a following good 1-beat packet gives pkt_cnt_o=1.
- Mid-packet violation: beats 1-2 pmp=1, beat 3 pmp=0, 5 beats total → FIFO holds 2 data entries then {err=1, last=1, 0}; beats 4-5 discarded; FSM returns to IDLE.
- Backpressure: push 16 beats with no pops → level_o=16, tready=0. Then pop_i and a pending beat in the same cycle → beat not accepted that cycle, accepted the next; data order preserved.
- Clear/reset: with drop_cnt_o=255 and another violation → stays at 255. clr_i in the same cycle as a violation → counters and flag read 0. rst_i mid-packet → level_o=0, and the next beat is handled as a first beat.
